uart_rx_deserializer: RTL and testbench
=======================================

Name: uart_rx_deserializer

Overview:
- UART receive-side counterpart of the TX serializer.
- Oversamples the asynchronous serial line `RX_IN` at `Prescale` clocks per bit and detects start bits, rejecting glitches.
- Samples data LSB first, checks optional parity and the stop bit, and presents a parallel word with a one-cycle `data_valid` pulse.
- Sits between the pad-side synchronizer and the RX FIFO/system controller.

Parameters:
- `DATA_WIDTH`, 8, number of data bits per frame.
- `PRESCALE_W`, 6, width of the `Prescale` input; legal prescale values are 8, 16 or 32.

Ports:
- `clk`  in  1  system clock, oversampling rate.
- `rst`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, already synchronized to `clk`; idle level high.
- `Prescale`  in  `PRESCALE_W`  clocks per bit (8/16/32).
- `PAR_EN`  in  1  1 = a parity bit follows the data bits.
- `PAR_TYP`  in  1  0 = even parity, 1 = odd parity.
- `P_DATA`  out  `DATA_WIDTH`  received word, valid when `data_valid`=1.
- `data_valid`  out  1  one-cycle pulse, frame received with no error.
- `par_err`  out  1  one-cycle pulse, parity mismatch.
- `stp_err`  out  1  one-cycle pulse, stop bit sampled low.

Behaviour:
- Reset:
  - Asynchronous, active-low. Forces IDLE and clears all counters and the shift register.
  - Outputs after reset: `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0.
  - Reset asserted mid-frame aborts the frame; no pulse is emitted.
- Configuration capture: `Prescale`, `PAR_EN` and `PAR_TYP` are latched on the IDLE->START transition. Changes mid-frame have no effect until the next frame.
- Counters:
  - `edge_cnt` counts 0..Prescale-1 within each bit.
  - `bit_cnt` counts the bits of the frame.
  - Sample point is `edge_cnt` == Prescale/2.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - `RX_IN`=0 -> START, with `edge_cnt`=0 in that cycle.
  - Otherwise stay in IDLE.
- START:
  - The sampled bit is 1 (glitch) -> return to IDLE at the sample point; no error pulse.
  - At `edge_cnt`=Prescale-1 -> DATA.
- DATA:
  - At the sample point, shift the sampled bit in LSB first: `shift` <= {bit, `shift`[DATA_WIDTH-1:1]}.
  - After `DATA_WIDTH` bits, at `edge_cnt`=Prescale-1 -> PARITY if `PAR_EN`, else STOP.
- PARITY:
  - Expected bit = ^`shift` for even parity; ~^`shift` for odd parity.
  - A mismatch sets an internal `par_flag`.
  - At end of bit -> STOP.
- STOP:
  - Sampled bit 0 sets an internal `stp_flag`.
  - At `edge_cnt`=Prescale-1, register the pulses: `data_valid`=!`par_flag`&!`stp_flag`, `par_err`=`par_flag`, `stp_err`=`stp_flag`.
  - `P_DATA` <= `shift` only when `data_valid`; otherwise it holds its last good value.
  - -> IDLE; flags clear.
- Latency:
  - Frame bits N = 1 + DATA_WIDTH + PAR_EN + 1.
  - The pulse is registered N*Prescale cycles after the cycle START is entered.
- Back-to-back frames: a start bit immediately after the stop bit is detected in IDLE one cycle later. This is within sampling tolerance, and no frame is lost.
- Simultaneous errors: `par_err` and `stp_err` may both pulse in the same cycle; `data_valid` is then 0.
- Line held low (break): a 0 stop bit gives `stp_err`. The block re-enters START next cycle and repeats each frame time while the line stays low.

Optional Feature:
- Macro: `RX_MAJORITY_VOTE_EN`.
- Defined: samples at `edge_cnt` = Prescale/2-1, Prescale/2 and Prescale/2+1. The bit value is the 2-of-3 majority, applied to start, data, parity and stop bits, and is decided at Prescale/2+1.
- Undefined: single sample at Prescale/2.
- All other timing is identical in both builds.

Decomposition:
- Package `uart_pkg`:
  - RX FSM state enum.
  - Parity constants `PAR_EVEN`=0, `PAR_ODD`=1.
  - Legal prescale constants 8/16/32.
  - Frame-length helper constant.
- Sub-module `uart_rx_sampler`: holds `edge_cnt`, the sample strobe and the majority vote (under the macro). It outputs `sampled_bit`, `sample_strb` and `bit_end`.
- The top level holds the FSM, `bit_cnt`, the shift register, the check flags and the output registers.

Test Plan:
- Prescale=8, PAR_EN=1 even, send 0xA5 with parity 0 and stop 1 -> `P_DATA`=0xA5, `data_valid` one cycle, 88 cycles after START entry; `par_err`=`stp_err`=0.
- Prescale=16, PAR_EN=1 odd, send 0x3C with a wrong parity bit 0 -> `par_err` pulse; `data_valid`=0; `P_DATA` holds its previous value.
- Prescale=32, PAR_EN=0, send 0xFF with stop bit 0 -> `stp_err` pulse at 320 cycles; `data_valid`=0.
- RX_IN low for 2 cycles only (Prescale=8) -> FSM returns to IDLE at the sample point; no pulses.
- Two back-to-back frames 0x00 then 0x81 (Prescale=8, no parity) -> two `data_valid` pulses 80±1 cycles apart, with the correct data in each.
- Drive `rst`=0 mid-DATA of frame 0x55 -> outputs 0 and FSM in IDLE immediately; the next clean frame 0x12 is received correctly.
- With `RX_MAJORITY_VOTE_EN`: a one-cycle inverted glitch at Prescale/2 on data bit 3 of 0x00 -> `P_DATA`=0x00 with `data_valid`.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receive types and constants: FSM state encoding, parity selection,
// legal oversampling rates and the frame-length helper.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE   = 3'd0,
        RX_START  = 3'd1,
        RX_DATA   = 3'd2,
        RX_PARITY = 3'd3,
        RX_STOP   = 3'd4
    } rx_state_e;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    localparam int PRESCALE_8  = 8;
    localparam int PRESCALE_16 = 16;
    localparam int PRESCALE_32 = 32;

    // Start and stop bits surround every frame.
    localparam int FRAME_FIXED_BITS = 2;

    function automatic int frame_bits(input int data_width, input logic par_en);
        return FRAME_FIXED_BITS + data_width + int'(par_en);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit oversampling counter and bit-value sampler for the UART receiver.
// With RX_MAJORITY_VOTE_EN defined the bit is a 2-of-3 vote around mid-bit.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  rx_in,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  sampled_bit,
    output logic                  sample_strb,
    output logic                  bit_end
);

    logic [PRESCALE_W-1:0] edge_cnt_q, edge_cnt_d;
    logic [PRESCALE_W-1:0] half;
    logic [PRESCALE_W-1:0] last;

    assign half = prescale >> 1;
    assign last = prescale - 1'b1;

    // Held at zero while idle so the first cycle of a start bit is edge 0.
    always_comb begin
        edge_cnt_d = '0;
        if (en && (edge_cnt_q != last)) begin
            edge_cnt_d = edge_cnt_q + 1'b1;
        end
    end

    assign bit_end = en && (edge_cnt_q == last);

`ifdef RX_MAJORITY_VOTE_EN
    logic s_early_q, s_early_d;
    logic s_mid_q, s_mid_d;

    always_comb begin
        s_early_d = s_early_q;
        s_mid_d   = s_mid_q;
        if (en && (edge_cnt_q == half - 1'b1)) s_early_d = rx_in;
        if (en && (edge_cnt_q == half))        s_mid_d   = rx_in;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_early_q <= 1'b1;
            s_mid_q   <= 1'b1;
        end else begin
            s_early_q <= s_early_d;
            s_mid_q   <= s_mid_d;
        end
    end

    // Third sample is the live line value; the decision lands at half+1.
    assign sample_strb = en && (edge_cnt_q == half + 1'b1);
    assign sampled_bit = (s_early_q & s_mid_q) | (s_early_q & rx_in) | (s_mid_q & rx_in);
`else
    assign sample_strb = en && (edge_cnt_q == half);
    assign sampled_bit = rx_in;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_cnt_q <= '0;
        end else begin
            edge_cnt_q <= edge_cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receiver: start detection with glitch rejection, LSB-first data, optional
// parity and stop check. RX_MAJORITY_VOTE_EN selects 3-sample voting in the sampler.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE_W = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err,
    output rx_state_e             fsm_state
);

    localparam int BCW = $clog2(DATA_WIDTH + 1);

    rx_state_e             state_q, state_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
    logic [PRESCALE_W-1:0] pres_q, pres_d;
    logic                  par_en_q, par_en_d;
    logic                  par_typ_q, par_typ_d;
    logic                  par_flag_q, par_flag_d;
    logic                  stp_flag_q, stp_flag_d;
    logic                  data_valid_q, data_valid_d;
    logic                  par_err_q, par_err_d;
    logic                  stp_err_q, stp_err_d;
    logic                  exp_par;

    logic sampled_bit;
    logic sample_strb;
    logic bit_end;

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .en          (state_q != RX_IDLE),
        .rx_in       (RX_IN),
        .prescale    (pres_q),
        .sampled_bit (sampled_bit),
        .sample_strb (sample_strb),
        .bit_end     (bit_end)
    );

    assign exp_par = (par_typ_q == PAR_ODD) ? ~^shift_q : ^shift_q;

    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        p_data_d     = p_data_q;
        pres_d       = pres_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        par_flag_d   = par_flag_q;
        stp_flag_d   = stp_flag_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!RX_IN) begin
                    state_d    = RX_START;
                    pres_d     = Prescale;
                    par_en_d   = PAR_EN;
                    par_typ_d  = PAR_TYP;
                    bit_cnt_d  = '0;
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                end
            end
            RX_START: begin
                if (sample_strb && sampled_bit) begin
                    state_d = RX_IDLE;
                end else if (bit_end) begin
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                if (sample_strb) begin
                    shift_d = {sampled_bit, shift_q[DATA_WIDTH-1:1]};
                end
                if (bit_end) begin
                    if (bit_cnt_q == BCW'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? RX_PARITY : RX_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end
            RX_PARITY: begin
                if (sample_strb && (sampled_bit != exp_par)) begin
                    par_flag_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (sample_strb && !sampled_bit) begin
                    stp_flag_d = 1'b1;
                end
                // P_DATA is meaningful only in the data_valid cycle; errored frames leave it untouched.
                if (bit_end) begin
                    data_valid_d = !par_flag_q && !stp_flag_q;
                    par_err_d    = par_flag_q;
                    stp_err_d    = stp_flag_q;
                    if (!par_flag_q && !stp_flag_q) begin
                        p_data_d = shift_q;
                    end
                    par_flag_d = 1'b0;
                    stp_flag_d = 1'b0;
                    state_d    = RX_IDLE;
                end
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= RX_IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            pres_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_flag_q   <= 1'b0;
            stp_flag_q   <= 1'b0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            p_data_q     <= p_data_d;
            pres_q       <= pres_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_flag_q   <= par_flag_d;
            stp_flag_q   <= stp_flag_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;
    assign fsm_state  = state_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: directed frames plus randomized frames, checked
// by a frame-level reference model feeding an expected queue (RX_MAJORITY_VOTE_EN aware).
module tb_uart_rx_deserializer;
    import uart_pkg::*;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          RX_IN = 1'b1;
    logic [PW-1:0] Prescale = PW'(8);
    logic          PAR_EN = 1'b0;
    logic          PAR_TYP = 1'b0;
    logic [DW-1:0] P_DATA;
    logic          data_valid;
    logic          par_err;
    logic          stp_err;
    rx_state_e     fsm_state;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Expected pulse word: {data_valid, par_err, stp_err, P_DATA}
    logic [DW+2:0] exp_q[$];
    int            exp_cyc_q[$];
    logic [DW-1:0] last_good = '0;
    int            next_free = 0;
    logic [DW+2:0] mon_e;
    int            mon_c;

    uart_rx_deserializer #(
        .DATA_WIDTH (DW),
        .PRESCALE_W (PW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .data_valid (data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err),
        .fsm_state  (fsm_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level model: a frame is caught one cycle after its start bit drops,
    // or one cycle after the receiver is back in idle if it was still busy.
    task automatic model_frame(input int s, input int n, input int p, input logic pe,
                               input logic se, input logic [DW-1:0] data);
        int   entry;
        logic dv;
        entry     = (s + 1 > next_free + 1) ? s + 1 : next_free + 1;
        next_free = entry + n * p;
        dv        = !pe && !se;
        if (dv) last_good = data;
        exp_q.push_back({dv, pe, se, last_good});
        exp_cyc_q.push_back(entry + n * p);
    endtask

    function automatic int rand_prescale();
        case ($urandom_range(0, 2))
            0:       return PRESCALE_8;
            1:       return PRESCALE_16;
            default: return PRESCALE_32;
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            RX_IN = 1'b1;
        end
    endtask

    task automatic drive_frame(input logic [DW-1:0] data, input int p, input logic pen,
                               input logic ptyp, input logic par_flip, input logic stop_bit,
                               input int glitch_off, input bit mess_cfg);
        logic bits[$];
        logic par_bit;
        int   s;
        int   n;
        s = 0;
        par_bit = (($countones(data) % 2) == 1) ^ (ptyp == PAR_ODD) ^ par_flip;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(data[i]);
        if (pen) bits.push_back(par_bit);
        bits.push_back(stop_bit);
        n = bits.size();
        Prescale = PW'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        for (int o = 0; o < n * p; o++) begin
            @(posedge clk);
            #1;
            if (o == 0) s = cyc;
            RX_IN = bits[o / p] ^ (o == glitch_off);
            if (mess_cfg && o == 2) begin
                Prescale = PW'(rand_prescale());
                PAR_EN   = 1'($urandom_range(0, 1));
                PAR_TYP  = 1'($urandom_range(0, 1));
            end
        end
        model_frame(s, n, p, pen && par_flip, !stop_bit, data);
    endtask

    task automatic glitch(input int p, input int g);
        int h;
        h = p / 2;
        Prescale = PW'(p);
        PAR_EN   = 1'b0;
        for (int o = 0; o < h + 5; o++) begin
            @(posedge clk);
            #1;
            RX_IN = (o < g) ? 1'b0 : 1'b1;
            if (o == 1)     check("glitch_enters_start", 32'(fsm_state), 32'(RX_START));
            if (o == h + 4) check("glitch_back_to_idle", 32'(fsm_state), 32'(RX_IDLE));
        end
    endtask

    // Monitor: every pulse cycle must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst && (data_valid || par_err || stp_err)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: dv=%b pe=%b se=%b data=0x%0h, none expected (cycle %0d)",
                         data_valid, par_err, stp_err, P_DATA, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                mon_c = exp_cyc_q.pop_front();
                check("pulse_flags", 32'({data_valid, par_err, stp_err}), 32'(mon_e[DW+2:DW]));
                check("p_data", 32'(P_DATA), 32'(mon_e[DW-1:0]));
                check("pulse_cycle", cyc, mon_c);
            end
        end
    end

    initial begin
        logic [DW-1:0] d55;
        int            s;
        int            p;

        rst   = 1'b0;
        RX_IN = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_p_data", 32'(P_DATA), 0);
        check("reset_data_valid", 32'(data_valid), 0);
        check("reset_par_err", 32'(par_err), 0);
        check("reset_stp_err", 32'(stp_err), 0);
        check("reset_state", 32'(fsm_state), 32'(RX_IDLE));
        @(negedge clk);
        rst = 1'b1;
        idle(10);

        drive_frame(8'hA5, 8, 1'b1, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0);
        idle(20);
        drive_frame(8'h3C, 16, 1'b1, PAR_ODD, 1'b1, 1'b1, -1, 1'b0);
        idle(40);
        drive_frame(8'hFF, 32, 1'b0, PAR_EVEN, 1'b0, 1'b0, -1, 1'b0);
        idle(70);

        glitch(8, 2);
        idle(16);
        glitch(16, 5);
        idle(32);

        drive_frame(8'h00, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0);
        drive_frame(8'h81, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0);
        idle(20);

        // Reset in the middle of the data bits of 0x55
        d55      = 8'h55;
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        for (int o = 0; o < 8 + 3 * 8 + 4; o++) begin
            @(posedge clk);
            #1;
            RX_IN = (o < 8) ? 1'b0 : d55[(o - 8) / 8];
        end
        check("no_pending_before_reset", exp_q.size(), 0);
        #2;
        rst = 1'b0;
        #1;
        check("midreset_p_data", 32'(P_DATA), 0);
        check("midreset_data_valid", 32'(data_valid), 0);
        check("midreset_par_err", 32'(par_err), 0);
        check("midreset_stp_err", 32'(stp_err), 0);
        check("midreset_state", 32'(fsm_state), 32'(RX_IDLE));
        RX_IN     = 1'b1;
        last_good = '0;
        next_free = 0;
        @(negedge clk);
        rst = 1'b1;
        idle(16);
        drive_frame(8'h12, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, -1, 1'b0);
        idle(20);

`ifdef RX_MAJORITY_VOTE_EN
        drive_frame(8'h00, 8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 1 + 4 * 8 + 4, 1'b0);
        idle(20);
        drive_frame(8'hF7, 16, 1'b1, PAR_ODD, 1'b0, 1'b1, 1 + 2 * 16 + 8, 1'b0);
        idle(20);
`endif

        // Line held low: two back-to-back break frames, each a stop error
        Prescale = PW'(8);
        PAR_EN   = 1'b0;
        @(posedge clk);
        #1;
        RX_IN = 1'b0;
        s     = cyc;
        model_frame(s, 10, 8, 1'b0, 1'b1, 8'h00);
        model_frame(s, 10, 8, 1'b0, 1'b1, 8'h00);
        for (int o = 1; o < 2 * 80 + 2; o++) begin
            @(posedge clk);
            #1;
            RX_IN = 1'b0;
        end
        idle(20);

        for (int i = 0; i < 40; i++) begin
            p = rand_prescale();
            drive_frame(DW'($urandom_range(0, 255)), p, 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                        ($urandom_range(0, 5) != 0), -1, 1'b1);
            idle($urandom_range(0, p));
        end

        for (int i = 0; i < 4000 && exp_q.size() > 0; i++) @(posedge clk);
        idle(4);
        check("drain_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
